// File: rtl/fnd_pkg.sv
// fnd_pkg: constants and helpers shared by the seven-segment scan blocks.
//   SEG_W          width of one packed segment pattern {a..g}, MSB = a
//   SEG_A..SEG_G   bit index of each segment inside a pattern
//   SEG_BLANK      all segments off (logical, before polarity)
//   width_of(n)    counter width for n states, never less than 1
package fnd_pkg;

  localparam int SEG_W = 7;

  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0;

  // $clog2(1) is 0, which would give zero-width counters.
  function automatic int width_of(input int n);
    if (n <= 1) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/fnd_tick_div.sv
// fnd_tick_div: free-running modulo-DIV counter with a terminal-count flag.
//   clk, rst_n   clock and asynchronous active-low reset
//   cnt          current count, 0..DIV-1
//   tc           high for the single cycle where cnt == DIV-1
module fnd_tick_div
  import fnd_pkg::*;
#(
  parameter int DIV = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic [width_of(DIV)-1:0] cnt,
  output logic                     tc
);

  localparam int CW = width_of(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  assign tc = (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (tc) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/fnd_scan_ctrl.sv
// fnd_scan_ctrl: time-multiplexed seven-segment scan controller for
// NUM_DIGITS common-node digits, with double-buffered loads, per-digit
// blink, a blank interval at each slot start and configurable polarity.
//   clk, rst_n     clock and asynchronous active-low reset
//   i_digit_seg    packed patterns, digit k at [7k+6:7k]
//   i_dp           decimal point per digit (1 = lit)
//   i_blink_mask   1 = digit blinks
//   i_load         strobe capturing the three data inputs into the shadow
//   i_disp_en      0 = all digits dark (scan keeps running)
//   o_seg/o_seg_dp segment and dp drive for the digit being scanned
//   o_seg_enb      one-hot digit enable
//   o_pending      shadow data waiting for the frame boundary
//   o_frame_tick   one-cycle pulse after each frame boundary
module fnd_scan_ctrl
  import fnd_pkg::*;
#(
  parameter int NUM_DIGITS  = 6,
  parameter int SCAN_DIV    = 5000,
  parameter int BLANK_CYC   = 16,
  parameter int BLINK_DIV   = 25000000,
  parameter int SEG_ACT_LOW = 0,
  parameter int ENB_ACT_LOW = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [SEG_W*NUM_DIGITS-1:0] i_digit_seg,
  input  logic [NUM_DIGITS-1:0]       i_dp,
  input  logic [NUM_DIGITS-1:0]       i_blink_mask,
  input  logic                        i_load,
  input  logic                        i_disp_en,
  output logic [SEG_W-1:0]            o_seg,
  output logic                        o_seg_dp,
  output logic [NUM_DIGITS-1:0]       o_seg_enb,
  output logic                        o_pending,
  output logic                        o_frame_tick
);

  localparam int IDX_W = width_of(NUM_DIGITS);
  localparam int PRE_W = width_of(SCAN_DIV);
  localparam int BLK_W = width_of(BLINK_DIV);
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [SEG_W-1:0]      SEG_POL  = (SEG_ACT_LOW != 0) ? {SEG_W{1'b1}} : {SEG_W{1'b0}};
  localparam logic                  DP_POL   = (SEG_ACT_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] ENB_POL  = (ENB_ACT_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  logic [PRE_W-1:0] pre_cnt;
  logic             scan_tc;
  logic [BLK_W-1:0] unused_blink_cnt;
  logic             blink_tc;
  logic [IDX_W-1:0] idx_reg;
  logic             blink_ph_reg;
  logic             frame;

  logic [SEG_W*NUM_DIGITS-1:0] shadow_seg_reg, active_seg_reg;
  logic [NUM_DIGITS-1:0]       shadow_dp_reg, active_dp_reg;
  logic [NUM_DIGITS-1:0]       shadow_mask_reg, active_mask_reg;
  logic                        pending_reg;
  logic                        frame_tick_reg;

  logic [SEG_W-1:0]      active_digit [NUM_DIGITS];
  logic                  in_window;
  logic                  lit;
  logic [SEG_W-1:0]      seg_next, seg_reg;
  logic                  dp_next, dp_reg;
  logic [NUM_DIGITS-1:0] enb_next, enb_reg;

  fnd_tick_div #(.DIV(SCAN_DIV)) u_scan_div (
    .clk   (clk),
    .rst_n (rst_n),
    .cnt   (pre_cnt),
    .tc    (scan_tc)
  );

  fnd_tick_div #(.DIV(BLINK_DIV)) u_blink_div (
    .clk   (clk),
    .rst_n (rst_n),
    .cnt   (unused_blink_cnt),
    .tc    (blink_tc)
  );

  // Last cycle of the last digit slot.
  assign frame = scan_tc && (idx_reg == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_reg        <= '0;
      blink_ph_reg   <= 1'b0;
      frame_tick_reg <= 1'b0;
    end else begin
      if (scan_tc) begin
        idx_reg <= (idx_reg == LAST_IDX) ? '0 : idx_reg + IDX_W'(1);
      end
      if (blink_tc) begin
        blink_ph_reg <= ~blink_ph_reg;
      end
      frame_tick_reg <= frame;
    end
  end

  // Double buffer: the shadow always follows i_load; the active copy only
  // changes at the frame boundary so a frame is never drawn with mixed data.
  // A load landing on the boundary itself goes straight to active.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_seg_reg  <= '0;
      shadow_dp_reg   <= '0;
      shadow_mask_reg <= '0;
      active_seg_reg  <= '0;
      active_dp_reg   <= '0;
      active_mask_reg <= '0;
      pending_reg     <= 1'b0;
    end else begin
      if (i_load) begin
        shadow_seg_reg  <= i_digit_seg;
        shadow_dp_reg   <= i_dp;
        shadow_mask_reg <= i_blink_mask;
      end
      if (frame) begin
        pending_reg <= 1'b0;
        if (i_load) begin
          active_seg_reg  <= i_digit_seg;
          active_dp_reg   <= i_dp;
          active_mask_reg <= i_blink_mask;
        end else if (pending_reg) begin
          active_seg_reg  <= shadow_seg_reg;
          active_dp_reg   <= shadow_dp_reg;
          active_mask_reg <= shadow_mask_reg;
        end
      end else if (i_load) begin
        pending_reg <= 1'b1;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign active_digit[gi] = active_seg_reg[gi*SEG_W +: SEG_W];
      assign enb_next[gi]     = lit && (idx_reg == IDX_W'(gi));
    end

    if (BLANK_CYC == 0) begin : g_no_blank
      assign in_window = 1'b1;
    end else begin : g_blank
      assign in_window = (pre_cnt >= PRE_W'(BLANK_CYC));
    end
  endgenerate

  always_comb begin
    lit      = i_disp_en && in_window && !(blink_ph_reg && active_mask_reg[idx_reg]);
    seg_next = SEG_BLANK;
    dp_next  = 1'b0;
    if (lit) begin
      seg_next = active_digit[idx_reg];
      dp_next  = active_dp_reg[idx_reg];
    end
  end

  // Registers hold logical (active-high) values; polarity is a pure XOR on
  // the way out, so the cleared registers already give inactive pin levels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_reg <= SEG_BLANK;
      dp_reg  <= 1'b0;
      enb_reg <= '0;
    end else begin
      seg_reg <= seg_next;
      dp_reg  <= dp_next;
      enb_reg <= enb_next;
    end
  end

  assign o_seg        = seg_reg ^ SEG_POL;
  assign o_seg_dp     = dp_reg ^ DP_POL;
  assign o_seg_enb    = enb_reg ^ ENB_POL;
  assign o_pending    = pending_reg;
  assign o_frame_tick = frame_tick_reg;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// tb_fnd_scan_ctrl: randomized and directed stimulus for fnd_scan_ctrl,
// checked every cycle against a reference model that derives the scan
// position, blink phase and frame boundaries from the cycle count since reset.
module tb_fnd_scan_ctrl;

  localparam int N     = 4;
  localparam int SDIV  = 8;
  localparam int BLANK = 2;
  localparam int BDIV  = 64;
  localparam int FRAME = N * SDIV;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7*N-1:0] i_digit_seg;
  logic [N-1:0]  i_dp;
  logic [N-1:0]  i_blink_mask;
  logic          i_load;
  logic          i_disp_en;
  logic [6:0]    o_seg;
  logic          o_seg_dp;
  logic [N-1:0]  o_seg_enb;
  logic          o_pending;
  logic          o_frame_tick;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state; m_k is the index of the next clock edge after reset.
  int             m_k;
  logic [7*N-1:0] m_act_seg, m_sh_seg;
  logic [N-1:0]   m_act_dp, m_sh_dp, m_act_mask, m_sh_mask;
  logic           m_pend;
  logic [6:0]     e_seg;
  logic           e_dp, e_tick, e_pend;
  logic [N-1:0]   e_enb;

  fnd_scan_ctrl #(
    .NUM_DIGITS  (N),
    .SCAN_DIV    (SDIV),
    .BLANK_CYC   (BLANK),
    .BLINK_DIV   (BDIV),
    .SEG_ACT_LOW (0),
    .ENB_ACT_LOW (1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_digit_seg  (i_digit_seg),
    .i_dp         (i_dp),
    .i_blink_mask (i_blink_mask),
    .i_load       (i_load),
    .i_disp_en    (i_disp_en),
    .o_seg        (o_seg),
    .o_seg_dp     (o_seg_dp),
    .o_seg_enb    (o_seg_enb),
    .o_pending    (o_pending),
    .o_frame_tick (o_frame_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s k=%0d got=%h exp=%h", tag, m_k, got, exp);
    end
  endtask

  task automatic m_reset();
    m_k        = 0;
    m_act_seg  = '0;
    m_sh_seg   = '0;
    m_act_dp   = '0;
    m_sh_dp    = '0;
    m_act_mask = '0;
    m_sh_mask  = '0;
    m_pend     = 1'b0;
  endtask

  // Advance the model over one clock edge using the inputs present at it.
  task automatic m_edge();
    int   pre, idx, ph;
    logic lit_m;
    pre   = m_k % SDIV;
    idx   = (m_k / SDIV) % N;
    ph    = (m_k / BDIV) % 2;
    lit_m = i_disp_en && (pre >= BLANK) && !((ph == 1) && m_act_mask[idx]);
    e_seg = lit_m ? m_act_seg[idx*7 +: 7] : 7'd0;
    e_dp  = lit_m && m_act_dp[idx];
    e_enb = lit_m ? ~(4'b0001 << idx) : 4'b1111;
    e_tick = ((m_k % FRAME) == FRAME - 1);
    if (e_tick) begin
      if (i_load) begin
        m_act_seg  = i_digit_seg;
        m_act_dp   = i_dp;
        m_act_mask = i_blink_mask;
      end else if (m_pend) begin
        m_act_seg  = m_sh_seg;
        m_act_dp   = m_sh_dp;
        m_act_mask = m_sh_mask;
      end
      m_pend = 1'b0;
    end else if (i_load) begin
      m_pend = 1'b1;
    end
    if (i_load) begin
      m_sh_seg  = i_digit_seg;
      m_sh_dp   = i_dp;
      m_sh_mask = i_blink_mask;
    end
    e_pend = m_pend;
    m_k++;
  endtask

  task automatic check_outputs(input string sfx);
    chk({"seg", sfx},  32'(o_seg),        32'(e_seg));
    chk({"dp", sfx},   32'(o_seg_dp),     32'(e_dp));
    chk({"enb", sfx},  32'(o_seg_enb),    32'(e_enb));
    chk({"pend", sfx}, 32'(o_pending),    32'(e_pend));
    chk({"tick", sfx}, 32'(o_frame_tick), 32'(e_tick));
  endtask

  task automatic step();
    @(posedge clk);
    m_edge();
    @(negedge clk);
    check_outputs("");
    i_load = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic load(input logic [7*N-1:0] s, input logic [N-1:0] dp, input logic [N-1:0] m);
    i_digit_seg  = s;
    i_dp         = dp;
    i_blink_mask = m;
    i_load       = 1'b1;
    $display("load k=%0d seg=%h dp=%b mask=%b", m_k, s, dp, m);
  endtask

  task automatic expect_inactive();
    e_seg = 7'd0; e_dp = 1'b0; e_enb = 4'b1111; e_pend = 1'b0; e_tick = 1'b0;
    check_outputs("_rst");
  endtask

  // Called at a negedge: pull reset asynchronously mid-cycle, check outputs
  // before any clock edge, then release on a later negedge.
  task automatic async_reset();
    i_load = 1'b0;
    #2 rst_n = 1'b0;
    #1 expect_inactive();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();
  endtask

  initial begin
    rst_n        = 1'b1;
    i_digit_seg  = '0;
    i_dp         = '0;
    i_blink_mask = '0;
    i_load       = 1'b0;
    i_disp_en    = 1'b1;
    #1 rst_n = 1'b0;
    #2 expect_inactive();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();

    // Initial load, pending until the first boundary, then the scan pattern.
    load({7'h79, 7'h6D, 7'h30, 7'h7E}, 4'b0001, 4'b0000);
    step();
    run(70);

    // Two loads in one frame: only the second should reach the display.
    while ((m_k % FRAME) != 2) step();
    load(28'h1234567, 4'b1010, 4'b0000);
    run(5);
    load(28'hABCDEF1, 4'b0101, 4'b0000);
    run(45);

    // Load exactly on the boundary cycle bypasses the shadow.
    while ((m_k % FRAME) != FRAME - 1) step();
    load(28'h5A5A5A5, 4'b1100, 4'b0000);
    run(40);

    // Blink digit 2 across several blink half-periods.
    load(28'hFFFFFFF, 4'b1111, 4'b0100);
    run(300);

    // Random traffic, with occasional boundary-aligned loads and dark cycles.
    for (int i = 0; i < 1500; i++) begin
      if ((m_k % FRAME) == FRAME - 1 && $urandom_range(0, 3) == 0) begin
        load(28'($urandom), 4'($urandom), 4'($urandom));
      end else if ($urandom_range(0, 19) == 0) begin
        load(28'($urandom), 4'($urandom), 4'($urandom));
      end
      i_disp_en = ($urandom_range(0, 15) != 0);
      step();
    end
    i_disp_en = 1'b1;

    // Reset mid-slot on digit 2; display restarts at digit 0 with blank data.
    while (!(((m_k / SDIV) % N) == 2 && (m_k % SDIV) == 4)) step();
    async_reset();
    run(70);
    load(28'h0F0F0F0, 4'b0011, 4'b0000);
    step();
    run(40);

    // Same again with the display disabled: enables must stay inactive.
    while (!(((m_k / SDIV) % N) == 2 && (m_k % SDIV) == 3)) step();
    i_disp_en = 1'b0;
    async_reset();
    load(28'h7777777, 4'b1111, 4'b0000);
    step();
    run(80);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
